// File: rtl/l_reader_arbiter.sv
// l_reader_arbiter
//   Shares one l_reader letter recogniser between N_REQ column-stream
//   requesters. A requester is granted the reader for a whole glyph: the
//   reader is restarted, the owner's 3-bit columns are forwarded through a
//   register, and the reader's L output is sampled once the glyph ends. One
//   result per glyph is reported, tagged with the requester index.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   restart_n  in   asynchronous active-low reset
//   req        in   [N_REQ]    requester i has a glyph to send
//   col_valid  in   [N_REQ]    column slice i is valid
//   col_bits   in   [3*N_REQ]  column for requester i at [3i+2:3i]
//   col_ready  out  [N_REQ]    column i accepted when valid & ready
//   grant      out  [N_REQ]    one-hot current owner, 0 when idle
//   rd_bits    out  [3]        registered column to the shared reader
//   rd_restart out             synchronous restart to the reader
//   rd_L       in              L output of the shared reader
//   done_valid out             one-cycle result pulse
//   done_id    out  [ID_W]     requester index of the result
//   done_L     out             glyph recognised as L
//   done_err   out             glyph aborted (done_L is then 0)
module l_reader_arbiter #(
  parameter int N_REQ    = 2,
  parameter int ID_W     = 1,
  parameter int MAX_COLS = 8,
  parameter int RES_LAT  = 1
) (
  input  logic               clk,
  input  logic               restart_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   col_valid,
  input  logic [3*N_REQ-1:0] col_bits,
  output logic [N_REQ-1:0]   col_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         rd_bits,
  output logic               rd_restart,
  input  logic               rd_L,
  output logic               done_valid,
  output logic [ID_W-1:0]    done_id,
  output logic               done_L,
  output logic               done_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRIME  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_COLS + 2);
  localparam int LAT_W = (RES_LAT > 1) ? $clog2(RES_LAT + 1) : 1;

  logic [2:0]       state_reg, state_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [ID_W-1:0]  owner_reg, owner_next;
  logic [ID_W-1:0]  last_owner_reg, last_owner_next;
  logic [2:0]       rd_bits_reg, rd_bits_next;
  logic [CNT_W-1:0] nb_cnt_reg, nb_cnt_next;
  logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
  logic             done_valid_reg, done_valid_next;
  logic [ID_W-1:0]  done_id_reg, done_id_next;
  logic             done_L_reg, done_L_next;
  logic             done_err_reg, done_err_next;

  // Owner's view of the request lines, selected by the one-hot grant.
  logic [2:0]       masked_bits [N_REQ];
  logic [2:0]       own_bits;
  logic             own_valid;
  logic             own_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign masked_bits[gi] = grant_reg[gi] ? col_bits[3*gi +: 3] : 3'b000;
    end
  endgenerate

  always_comb begin
    own_bits = 3'b000;
    for (int i = 0; i < N_REQ; i++) begin
      own_bits = own_bits | masked_bits[i];
    end
  end

  assign own_valid = |(col_valid & grant_reg);
  assign own_req   = |(req & grant_reg);

  // Round-robin pick: first set req strictly after last_owner, wrapping.
  // Offsets are scanned from farthest to nearest so the nearest one wins.
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  int               pick_pos;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_pos   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      pick_pos = (int'(last_owner_reg) + k) % N_REQ;
      if (req[pick_pos[SEL_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(pick_pos);
      end
    end
  end

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_pick
      assign pick_onehot[gi] = pick_found && (pick_idx == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    rd_bits_next    = 3'b000;
    nb_cnt_next     = nb_cnt_reg;
    lat_cnt_next    = lat_cnt_reg;
    done_valid_next = 1'b0;
    done_id_next    = done_id_reg;
    done_L_next     = done_L_reg;
    done_err_next   = done_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          grant_next = pick_onehot;
          owner_next = pick_idx;
          state_next = ST_PRIME;
        end
      end

      ST_PRIME: begin
        nb_cnt_next = '0;
        state_next  = ST_STREAM;
      end

      ST_STREAM: begin
        // The reader cannot stall, so a missing column mid-glyph, an
        // over-long glyph or a withdrawn request all abort the glyph.
        if (!own_req) begin
          state_next      = ST_REPORT;
          done_valid_next = 1'b1;
          done_id_next    = owner_reg;
          done_L_next     = 1'b0;
          done_err_next   = 1'b1;
        end else if (own_valid) begin
          if (own_bits == 3'b000) begin
            // Leading blanks are forwarded; a blank after data ends the glyph.
            if (nb_cnt_reg != '0) begin
              state_next   = ST_WAIT;
              lat_cnt_next = '0;
            end
          end else if (nb_cnt_reg == CNT_W'(MAX_COLS)) begin
            state_next      = ST_REPORT;
            done_valid_next = 1'b1;
            done_id_next    = owner_reg;
            done_L_next     = 1'b0;
            done_err_next   = 1'b1;
          end else begin
            nb_cnt_next  = nb_cnt_reg + CNT_W'(1);
            rd_bits_next = own_bits;
          end
        end else if (nb_cnt_reg != '0) begin
          state_next      = ST_REPORT;
          done_valid_next = 1'b1;
          done_id_next    = owner_reg;
          done_L_next     = 1'b0;
          done_err_next   = 1'b1;
        end
      end

      ST_WAIT: begin
        if (lat_cnt_reg == LAT_W'(RES_LAT - 1)) begin
          state_next      = ST_REPORT;
          done_valid_next = 1'b1;
          done_id_next    = owner_reg;
          done_L_next     = rd_L;
          done_err_next   = 1'b0;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_W'(1);
        end
      end

      ST_REPORT: begin
        last_owner_next = owner_reg;
        grant_next      = '0;
        state_next      = ST_IDLE;
      end

      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      owner_reg      <= '0;
      last_owner_reg <= ID_W'(N_REQ - 1);
      rd_bits_reg    <= 3'b000;
      nb_cnt_reg     <= '0;
      lat_cnt_reg    <= '0;
      done_valid_reg <= 1'b0;
      done_id_reg    <= '0;
      done_L_reg     <= 1'b0;
      done_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      rd_bits_reg    <= rd_bits_next;
      nb_cnt_reg     <= nb_cnt_next;
      lat_cnt_reg    <= lat_cnt_next;
      done_valid_reg <= done_valid_next;
      done_id_reg    <= done_id_next;
      done_L_reg     <= done_L_next;
      done_err_reg   <= done_err_next;
    end
  end

  // The reader is held in restart for the whole IDLE and PRIME period, which
  // gives it at least two restart cycles between glyphs.
  assign rd_restart = (state_reg == ST_IDLE) || (state_reg == ST_PRIME);
  assign col_ready  = (state_reg == ST_STREAM) ? grant_reg : '0;
  assign grant      = grant_reg;
  assign rd_bits    = rd_bits_reg;
  assign done_valid = done_valid_reg;
  assign done_id    = done_id_reg;
  assign done_L     = done_L_reg;
  assign done_err   = done_err_reg;

endmodule

// File: tb/tb_l_reader_arbiter.sv
module tb_l_reader_arbiter;
  localparam int N    = 2;
  localparam int IDW  = 1;
  localparam int MAXC = 8;

  logic           clk = 1'b0;
  logic           restart_n;
  logic [N-1:0]   req;
  logic [N-1:0]   col_valid;
  logic [3*N-1:0] col_bits;
  logic [N-1:0]   col_ready;
  logic [N-1:0]   grant;
  logic [2:0]     rd_bits;
  logic           rd_restart;
  logic           rd_L;
  logic           done_valid;
  logic [IDW-1:0] done_id;
  logic           done_L;
  logic           done_err;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q [$];   // {id, L, err}
  logic [2:0] glyph_q [$];
  logic       prev_dv = 1'b0;
  logic [1:0] rdr_st;

  l_reader_arbiter #(.N_REQ(N), .ID_W(IDW), .MAX_COLS(MAXC), .RES_LAT(1)) dut (
    .clk(clk), .restart_n(restart_n), .req(req), .col_valid(col_valid),
    .col_bits(col_bits), .col_ready(col_ready), .grant(grant),
    .rd_bits(rd_bits), .rd_restart(rd_restart), .rd_L(rd_L),
    .done_valid(done_valid), .done_id(done_id), .done_L(done_L),
    .done_err(done_err)
  );

  always #5 clk = ~clk;

  // Reader model: L = a 111 column followed by one or more 001 columns.
  // States: 0 start, 1 seen 111, 2 seen 111 then 001, 3 reject.
  always @(posedge clk) begin
    if (rd_restart) rdr_st <= 2'd0;
    else begin
      case (rdr_st)
        2'd0: if (rd_bits == 3'b111) rdr_st <= 2'd1;
              else if (rd_bits != 3'b000) rdr_st <= 2'd3;
        2'd1: if (rd_bits == 3'b001) rdr_st <= 2'd2;
              else if (rd_bits != 3'b000) rdr_st <= 2'd3;
        2'd2: if (rd_bits != 3'b001 && rd_bits != 3'b000) rdr_st <= 2'd3;
        default: rdr_st <= 2'd3;
      endcase
    end
  end
  assign rd_L = (rdr_st == 2'd2) && (rd_bits == 3'b000);

  // Result monitor: pops the scoreboard on every done_valid pulse.
  always @(negedge clk) begin
    if (restart_n && done_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got id=%0d L=%0d err=%0d, required no result", done_id, done_L, done_err);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if ({done_id, done_L, done_err} !== e) begin
          failures++;
          $display("FAIL done_result: got id=%0d L=%0d err=%0d, required id=%0d L=%0d err=%0d",
                   done_id, done_L, done_err, e[2], e[1], e[0]);
        end else
          $display("result id=%0d L=%0d err=%0d ok", done_id, done_L, done_err);
      end
      checks++;
      if (prev_dv) begin
        failures++;
        $display("FAIL done_pulse: done_valid high two cycles in a row, required single pulse");
      end
    end
    prev_dv = restart_n && done_valid;
  end

  task automatic apply_reset();
    restart_n = 1'b0;
    req = '0; col_valid = '0; col_bits = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    restart_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one glyph from glyph_q for requester id. bubble_after: column
  // index after which one invalid cycle is inserted (-1 for none).
  task automatic send_glyph(input int id, input logic [N-1:0] drop_mask,
                            input int bubble_after, input logic keep,
                            input logic exp_L, input logic exp_err);
    int cyc;
    int nb;
    logic [2:0] c;
    logic [2:0] exp_rd;
    logic [N-1:0] exp_g;
    exp_g = N'(1) << id;
    req[id] = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!grant[id] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!grant[id]) begin
      failures++;
      $display("FAIL grant_timeout: grant=%b, required bit %0d set", grant, id);
      req[id] = 1'b0;
      return;
    end
    checks++;
    if (grant !== exp_g) begin
      failures++;
      $display("FAIL grant_onehot: grant=%b, required %b", grant, exp_g);
    end
    checks++;
    if (rd_restart !== 1'b1 || col_ready !== '0 || rd_bits !== 3'b000) begin
      failures++;
      $display("FAIL prime: rd_restart=%b col_ready=%b rd_bits=%b, required 1 00 000", rd_restart, col_ready, rd_bits);
    end
    req = req & ~drop_mask;
    exp_q.push_back({id[0], exp_L, exp_err});
    @(negedge clk);
    nb = 0;
    for (int i = 0; i < glyph_q.size(); i++) begin
      c = glyph_q[i];
      col_valid[id] = 1'b1;
      col_bits[3*id +: 3] = c;
      checks++;
      if (col_ready !== exp_g || grant !== exp_g || rd_restart !== 1'b0) begin
        failures++;
        $display("FAIL stream_ready: col_ready=%b grant=%b rd_restart=%b, required %b %b 0", col_ready, grant, rd_restart, exp_g, exp_g);
      end
      exp_rd = c;
      if (c != 3'b000) begin
        nb++;
        if (nb > MAXC) exp_rd = 3'b000;
      end
      @(negedge clk);
      checks++;
      if (rd_bits !== exp_rd) begin
        failures++;
        $display("FAIL rd_bits: col %0d got %b, required %b", i, rd_bits, exp_rd);
      end
      $display("col id=%0d bits=%b rd_bits=%b", id, c, rd_bits);
      if (i == bubble_after) begin
        col_valid[id] = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_bits !== 3'b000) begin
          failures++;
          $display("FAIL bubble_rd_bits: got %b, required 000", rd_bits);
        end
        break;
      end
    end
    col_valid[id] = 1'b0;
    col_bits[3*id +: 3] = 3'b000;
    if (!keep) req[id] = 1'b0;
  endtask

  task automatic wait_results();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || grant !== '0) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || grant !== '0) begin
      failures++;
      $display("FAIL result_timeout: pending=%0d grant=%b, required 0 and 00", exp_q.size(), grant);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    restart_n = 1'b0;
    req = '0; col_valid = '0; col_bits = '0;
    @(negedge clk);
    checks++;
    if (grant !== '0 || col_ready !== '0 || rd_bits !== 3'b000 || rd_restart !== 1'b1 ||
        done_valid !== 1'b0 || done_L !== 1'b0 || done_err !== 1'b0 || done_id !== '0) begin
      failures++;
      $display("FAIL reset_state: grant=%b col_ready=%b rd_bits=%b rd_restart=%b done=%b%b%b%b, required 00 00 000 1 0000",
               grant, col_ready, rd_bits, rd_restart, done_valid, done_id, done_L, done_err);
    end
    restart_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_l();
    glyph_q = '{3'b000, 3'b111, 3'b001, 3'b000};
    send_glyph(0, '0, -1, 1'b0, 1'b1, 1'b0);
    // Terminator accepted at edge k, we are in cycle k+1: result must be in k+2.
    checks++;
    if (done_valid !== 1'b0) begin
      failures++;
      $display("FAIL l_early: done_valid=%b in WAIT cycle, required 0", done_valid);
    end
    @(negedge clk);
    checks++;
    if (done_valid !== 1'b1) begin
      failures++;
      $display("FAIL l_latency: done_valid=%b two cycles after terminator, required 1", done_valid);
    end
    wait_results();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 2'b11;
    glyph_q = '{3'b111, 3'b101, 3'b111, 3'b000};
    send_glyph(0, '0, -1, 1'b1, 1'b0, 1'b0);
    send_glyph(1, 2'b01, -1, 1'b0, 1'b0, 1'b0);
    wait_results();
  endtask

  task automatic test_bubble();
    glyph_q = '{3'b111, 3'b001};
    send_glyph(0, '0, 0, 1'b0, 1'b0, 1'b1);
    wait_results();
    checks++;
    if (rd_restart !== 1'b1 || col_ready !== '0) begin
      failures++;
      $display("FAIL bubble_idle: rd_restart=%b col_ready=%b, required 1 00", rd_restart, col_ready);
    end
  endtask

  task automatic test_max_cols();
    glyph_q.delete();
    for (int i = 0; i <= MAXC; i++) glyph_q.push_back(3'b111);
    send_glyph(1, '0, -1, 1'b0, 1'b0, 1'b1);
    wait_results();
  endtask

  task automatic test_non_owner();
    apply_reset();
    req[1] = 1'b1;
    col_valid[1] = 1'b1;
    col_bits[5:3] = 3'b111;
    glyph_q = '{3'b111, 3'b001, 3'b001, 3'b000};
    send_glyph(0, '0, -1, 1'b0, 1'b1, 1'b0);
    glyph_q = '{3'b111, 3'b101, 3'b111, 3'b000};
    send_glyph(1, '0, -1, 1'b0, 1'b0, 1'b0);
    wait_results();
  endtask

  task automatic test_reset_mid_stream();
    int cyc;
    req[0] = 1'b1;
    cyc = 0;
    while (col_ready[0] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    col_valid[0] = 1'b1;
    col_bits[2:0] = 3'b111;
    repeat (2) @(negedge clk);
    restart_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || col_ready !== '0 || rd_bits !== 3'b000 || rd_restart !== 1'b1 || done_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: grant=%b col_ready=%b rd_bits=%b rd_restart=%b done_valid=%b, required 00 00 000 1 0",
               grant, col_ready, rd_bits, rd_restart, done_valid);
    end
    req = '0; col_valid = '0; col_bits = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    restart_n = 1'b1;
    repeat (3) @(negedge clk);
    glyph_q = '{3'b111, 3'b001, 3'b000};
    send_glyph(0, '0, -1, 1'b0, 1'b1, 1'b0);
    wait_results();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_l();
    test_back_to_back();
    test_bubble();
    test_max_cols();
    test_non_owner();
    test_reset_mid_stream();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
